seg7_to_bcd_reader: RTL
=======================

Name: seg7_to_bcd_reader

Overview:
- Reads an active-low 7-segment pattern bus, debounces it, and recovers the BCD digit it shows.
- It is the reverse of the team's registered BCD-to-7-segment driver, using the same segment encoding.
- Used to monitor or loop back display buses and to read digits from external 7-segment sources.
- Reports valid, blank and illegal patterns, pulses a strobe when the accepted value changes, and counts illegal patterns.

Parameters:
- STABLE_CYCLES, 4, consecutive unchanged cycles needed before a pattern is accepted. Legal range 1 .. 2^CNT_W-1.
- CNT_W, 3, width of the stability counter.
- ERR_W, 8, width of the saturating illegal-pattern counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- seg_in  input  7  active-low segments {g,f,e,d,c,b,a}, bit0 = a. May be asynchronous to clock.
- bcd_out  output  4  last accepted digit 0-9; 4'hF when blank or illegal.
- valid  output  1  accepted pattern is a legal digit.
- blank  output  1  accepted pattern is all-off (7'b111_1111).
- err  output  1  accepted pattern is neither a digit nor blank.
- strobe  output  1  one-cycle pulse when a newly accepted pattern differs from the previously accepted one.
- err_count  output  ERR_W  saturating count of illegal-pattern acceptances.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - seg_q1, seg_q2 and seg_prev to 7'h7F;
  - state to S_BLANK, cnt to 0, acc_pat to 7'h7F;
  - bcd_out to 4'hF, valid to 0, blank to 1, err to 0, strobe to 0, err_count to 0.
- Input path, every edge: seg_q1 <= seg_in; seg_q2 <= seg_q1; seg_prev <= seg_q2. changed = (seg_q2 != seg_prev).
- Decode table (active-low):
  - 0 = 100_0000, 1 = 111_1001, 2 = 010_0100, 3 = 011_0000, 4 = 001_1001;
  - 5 = 001_0010, 6 = 000_0010, 7 = 111_1000, 8 = 000_0000, 9 = 001_0000;
  - blank = 111_1111; every other code is illegal.
- FSM states: S_BLANK, S_SETTLE, S_LOCKED.
  - Any state, changed = 1: cnt <= 0, state <= S_SETTLE. Outputs hold their last accepted values. changed has priority over acceptance in the same cycle.
  - S_SETTLE, changed = 0, cnt != STABLE_CYCLES-1: cnt <= cnt+1.
  - S_SETTLE, changed = 0, cnt == STABLE_CYCLES-1: accept seg_q2 and set cnt <= 0.
    - Legal digit: bcd_out = digit, valid = 1, blank = 0, err = 0, state <= S_LOCKED.
    - Blank: bcd_out = F, valid = 0, blank = 1, err = 0, state <= S_BLANK.
    - Illegal: bcd_out = F, valid = 0, blank = 0, err = 1, state <= S_LOCKED, err_count += 1 saturating at 2^ERR_W-1.
    - acc_pat <= seg_q2. strobe = 1 for exactly one cycle iff seg_q2 != acc_pat.
  - S_LOCKED / S_BLANK, changed = 0: hold all outputs; cnt stays 0; strobe = 0.
- Latency: if seg_in holds pattern P from before edge k, outputs reflect P after edge k+STABLE_CYCLES+2.
- Any change before acceptance restarts the count. Glitches shorter than STABLE_CYCLES+1 cycles never reach the outputs.
- A glitch that returns to the accepted pattern re-accepts the same pattern with no strobe. An illegal pattern is counted again each time it is re-accepted.
- err_count clears only on reset and never wraps.
- Reset mid-settle: all state returns to reset values immediately; the settling pattern is discarded.
- All outputs are registered, with no combinational path from seg_in.

Test Plan:
- Reset, then seg_in = 7'h7F held: blank = 1, bcd_out = F, valid = 0, strobe never pulses, err_count = 0.
- Step seg_in 7'h7F -> 7'b010_0100 before edge k (STABLE_CYCLES = 4): at edge k+6 bcd_out = 2, valid = 1, blank = 0, strobe = 1 for one cycle; no output change before k+6.
- Sweep digits 0-9, each held 10 cycles: bcd_out follows 0..9, one strobe per digit; back-to-back identical digits give no second strobe.
- From locked digit 7, apply a 3-cycle glitch to 7'b000_0000, then return to 7: bcd_out stays 7 throughout, no strobe.
- Apply illegal 7'b011_1111 stably, then blank, repeated 300 times: err = 1 and bcd_out = F on each illegal acceptance; err_count saturates at 255.
- Assert reset for 1 cycle mid-settle on digit 5: outputs return to reset values the same cycle; after release with 5 still applied, 5 is accepted STABLE_CYCLES+2 edges later with strobe = 1.

Source files
------------

// File: rtl/seg7_to_bcd_reader.sv
// Debounced active-low 7-segment pattern reader: recovers the BCD digit shown,
// flags blank/illegal patterns, strobes on a changed acceptance and counts illegal ones.
module seg7_to_bcd_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3,
  parameter int ERR_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  output logic [3:0]       bcd_out,
  output logic             valid,
  output logic             blank,
  output logic             err,
  output logic             strobe,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;

  typedef enum logic [1:0] {
    S_BLANK  = 2'd0,
    S_SETTLE = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  logic [6:0]       r_seg_q1;
  logic [6:0]       r_seg_q2;
  logic [6:0]       r_seg_prev;
  logic [6:0]       r_acc_pat;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bcd;
  logic             r_valid;
  logic             r_blank;
  logic             r_err;
  logic             r_strobe;
  logic [ERR_W-1:0] r_err_count;

  logic             w_changed;
  logic             w_is_digit;
  logic             w_is_blank;
  logic [3:0]       w_digit;

  assign w_changed  = (r_seg_q2 != r_seg_prev);
  assign w_is_blank = (r_seg_q2 == SEG_OFF);

  // Inverse of the BCD-to-7-segment driver table, segments {g,f,e,d,c,b,a} active-low
  always_comb begin
    w_is_digit = 1'b1;
    w_digit    = 4'hF;
    case (r_seg_q2)
      7'b100_0000: w_digit = 4'd0;
      7'b111_1001: w_digit = 4'd1;
      7'b010_0100: w_digit = 4'd2;
      7'b011_0000: w_digit = 4'd3;
      7'b001_1001: w_digit = 4'd4;
      7'b001_0010: w_digit = 4'd5;
      7'b000_0010: w_digit = 4'd6;
      7'b111_1000: w_digit = 4'd7;
      7'b000_0000: w_digit = 4'd8;
      7'b001_0000: w_digit = 4'd9;
      default:     w_is_digit = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_seg_q1    <= SEG_OFF;
      r_seg_q2    <= SEG_OFF;
      r_seg_prev  <= SEG_OFF;
      r_state     <= S_BLANK;
      r_cnt       <= '0;
      r_acc_pat   <= SEG_OFF;
      r_bcd       <= 4'hF;
      r_valid     <= 1'b0;
      r_blank     <= 1'b1;
      r_err       <= 1'b0;
      r_strobe    <= 1'b0;
      r_err_count <= '0;
    end else begin
      // Two flops resynchronise seg_in; the third holds the previous sample for change detect
      r_seg_q1   <= seg_in;
      r_seg_q2   <= r_seg_q1;
      r_seg_prev <= r_seg_q2;
      r_strobe   <= 1'b0;

      if (w_changed) begin
        r_cnt   <= '0;
        r_state <= S_SETTLE;
      end else if (r_state == S_SETTLE) begin
        if (r_cnt != CNT_LAST) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cnt     <= '0;
          r_acc_pat <= r_seg_q2;
          r_strobe  <= (r_seg_q2 != r_acc_pat);
          if (w_is_digit) begin
            r_bcd   <= w_digit;
            r_valid <= 1'b1;
            r_blank <= 1'b0;
            r_err   <= 1'b0;
            r_state <= S_LOCKED;
          end else if (w_is_blank) begin
            r_bcd   <= 4'hF;
            r_valid <= 1'b0;
            r_blank <= 1'b1;
            r_err   <= 1'b0;
            r_state <= S_BLANK;
          end else begin
            r_bcd   <= 4'hF;
            r_valid <= 1'b0;
            r_blank <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_LOCKED;
            if (r_err_count != {ERR_W{1'b1}}) r_err_count <= r_err_count + 1'b1;
          end
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign bcd_out   = r_bcd;
  assign valid     = r_valid;
  assign blank     = r_blank;
  assign err       = r_err;
  assign strobe    = r_strobe;
  assign err_count = r_err_count;

endmodule
